spi_word_tx: RTL

SPI_WORD_TX -- requirements
Module: spi_word_tx

---
 rtl/spi_word_tx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_word_tx.sv
// FIFO-buffered SPI word transmitter: MSB-first serializer with framed active-low chip select.
// Optional build macro SPI_WORD_TX_PARITY_EN drives the word's odd-parity bit during the inter-word gap.

module spi_word_tx #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        en_i,
   input  logic [DATA_WIDTH-1:0]       data_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   output logic                        spi_cs_no,
   output logic                        spi_sdo_o,
   output logic                        busy_o,
   output logic [15:0]                 sent_count_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, TRAIL} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  ready_q, ready_d;
   logic                  cs_q, cs_d;
   logic                  sdo_q, sdo_d;
   logic                  busy_q, busy_d;
   logic [15:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]      bit_q, bit_d;
`ifdef SPI_WORD_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   logic                  push;
   logic                  pop;
   logic                  start_ok;
   logic [DATA_WIDTH-1:0] head;

   always_comb begin
      push     = valid_i && ready_q;
      start_ok = (level_q != '0) && en_i;
      head     = mem_q[rd_ptr_q];
      pop      = 1'b0;

      state_d  = state_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cs_d     = cs_q;
      sdo_d    = sdo_q;
      count_d  = count_q;
      shreg_d  = shreg_q;
      bit_d    = bit_q;
`ifdef SPI_WORD_TX_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = LEAD;
               cs_d    = 1'b0;
               sdo_d   = 1'b0;
            end
         end
         LEAD: pop = 1'b1;
         SHIFT: begin
            if (bit_q == LAST_BIT) begin
               state_d = GAP;
               count_d = count_q + 16'd1;
`ifdef SPI_WORD_TX_PARITY_EN
               sdo_d   = parity_q;
`else
               sdo_d   = 1'b0;
`endif
            end else begin
               bit_d   = bit_q + CNT_W'(1);
               sdo_d   = shreg_q[DATA_WIDTH-1];
               shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end
         end
         // The back-to-back decision sees only the pre-edge level, so a same-cycle push cannot chain.
         GAP: begin
            if (start_ok) begin
               pop = 1'b1;
            end else begin
               state_d = TRAIL;
               sdo_d   = 1'b0;
            end
         end
         TRAIL: begin
            state_d = IDLE;
            cs_d    = 1'b1;
            sdo_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
            cs_d    = 1'b1;
            sdo_d   = 1'b0;
         end
      endcase

      // Loading a word puts its MSB on the line at once; the rest wait in the shifter.
      if (pop) begin
         state_d  = SHIFT;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         sdo_d    = head[DATA_WIDTH-1];
         shreg_d  = {head[DATA_WIDTH-2:0], 1'b0};
         bit_d    = '0;
`ifdef SPI_WORD_TX_PARITY_EN
         parity_d = ~^head;
`endif
      end

      if (push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      ready_d = (level_d < FULL_LVL);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ready_q  <= 1'b1;
         cs_q     <= 1'b1;
         sdo_q    <= 1'b0;
         busy_q   <= 1'b0;
         count_q  <= '0;
         shreg_q  <= '0;
         bit_q    <= '0;
`ifdef SPI_WORD_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ready_q  <= ready_d;
         cs_q     <= cs_d;
         sdo_q    <= sdo_d;
         busy_q   <= busy_d;
         count_q  <= count_d;
         shreg_q  <= shreg_d;
         bit_q    <= bit_d;
`ifdef SPI_WORD_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign ready_o      = ready_q;
   assign spi_cs_no    = cs_q;
   assign spi_sdo_o    = sdo_q;
   assign busy_o       = busy_q;
   assign sent_count_o = count_q;
   assign fifo_level_o = level_q;

endmodule
